// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, loadable instruction memory and a
// registered valid/ready output, with one bubble inserted after every branch redirect.
module instr_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 64,
    parameter int              AW       = 6,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [31:0]     prog_data,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [31:0]     instruction,
    output logic [6:0]      OPCode,
    output logic [XLEN-1:0] pc_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;
    logic [31:0]     r_mem [DEPTH];

    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_target;
    logic [AW-1:0]   w_idx;
    logic [AW-1:0]   w_idx_next;

    assign w_pc_next  = r_pc + XLEN'(4);
    assign w_target   = branch_target & ~XLEN'(3);
    assign w_idx      = r_pc[AW+1:2];
    assign w_idx_next = w_pc_next[AW+1:2];

    // NOTE: the memory has no reset branch; a reset loop over every word would
    // turn it into flops and would also wipe the loaded program on reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments, so a read of r_mem in
    // the same edge as a write to that index still sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (branch_taken) begin
                        r_pc <= w_target;
                    end else begin
                        r_instr <= r_mem[w_idx];
                        r_valid <= 1'b1;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    // A redirect discards any handshake happening in the same cycle.
                    if (branch_taken) begin
                        r_pc    <= w_target;
                        r_valid <= 1'b0;
                        r_state <= S_FETCH;
                    end else if (r_valid && out_ready) begin
                        r_pc    <= w_pc_next;
                        r_instr <= r_mem[w_idx_next];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_valid;
    assign instruction = r_instr;
    assign OPCode      = r_instr[6:0];
    assign pc_out      = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run compared against a presentation-level reference model.
module tb_instr_fetch_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic            clk;
    logic            reset;
    logic            start;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [31:0]     prog_data;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            out_ready;
    logic            out_valid;
    logic [31:0]     instruction;
    logic [6:0]      OPCode;
    logic [XLEN-1:0] pc_out;

    int errors = 0;
    int checks = 0;

    logic [31:0]  tb_mem [DEPTH];
    logic [103:0] obs;
    logic [103:0] exp_v;

    assign obs = {out_valid, pc_out, instruction, OPCode};

    instr_fetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .RESET_PC('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .instruction  (instruction),
        .OPCode       (OPCode),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [103:0] pack(input logic v, input logic [63:0] pc, input logic [31:0] w);
        return {v, pc, w, w[6:0]};
    endfunction

    task automatic write_word(input int idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(idx);
        prog_data = data;
        tick();
        prog_we     = 1'b0;
        tb_mem[idx] = data;
    endtask

    // Redirect and wait out the bubble; leaves the target presented.
    task automatic redirect(input logic [63:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        tick();
        branch_taken = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs !== pack(1'b0, 64'h0, 32'h0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, pack(1'b0, 64'h0, 32'h0));
        end
        tick();
        checks++;
        if (obs !== pack(1'b0, 64'h0, 32'h0)) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", obs, pack(1'b0, 64'h0, 32'h0));
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
        write_word(0, 32'h0000_0033);
        write_word(1, 32'h0000_0003);
        write_word(2, 32'h0000_0023);
        write_word(3, 32'h0000_0063);
    endtask

    task automatic test_program_load();
        logic [6:0] ops [3];
        ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_bubble: out_valid got %b expected 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== {1'b1, 64'(i * 4), tb_mem[i], ops[i]}) begin
                errors++;
                $display("FAIL load_stream[%0d]: got %h expected %h", i, obs, {1'b1, 64'(i * 4), tb_mem[i], ops[i]});
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== pack(1'b1, 64'h8, 32'h0000_0023)) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got %h expected %h", i, obs, pack(1'b1, 64'h8, 32'h0000_0023));
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (obs !== {1'b1, 64'hC, 32'h0000_0063, 7'b1100011}) begin
            errors++;
            $display("FAIL backpressure_release: got %h expected %h", obs, {1'b1, 64'hC, 32'h0000_0063, 7'b1100011});
        end
    endtask

    task automatic test_branch();
        redirect(64'h4);
        checks++;
        if (obs !== pack(1'b1, 64'h4, tb_mem[1])) begin
            errors++;
            $display("FAIL branch_setup: got %h expected %h", obs, pack(1'b1, 64'h4, tb_mem[1]));
        end
        branch_taken  = 1'b1;
        branch_target = 64'h2E;
        out_ready     = 1'b1;
        tick();
        branch_taken = 1'b0;
        out_ready    = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pc_out !== 64'h2C) begin
            errors++;
            $display("FAIL branch_bubble: got valid=%b pc=%h expected valid=0 pc=2c", out_valid, pc_out);
        end
        tick();
        checks++;
        if (obs !== pack(1'b1, 64'h2C, tb_mem[11])) begin
            errors++;
            $display("FAIL branch_target: got %h expected %h", obs, pack(1'b1, 64'h2C, tb_mem[11]));
        end
    endtask

    task automatic test_wrap();
        redirect(64'hF8);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== pack(1'b1, 64'hF8 + 64'(i * 4), tb_mem[(62 + i) % DEPTH])) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, pack(1'b1, 64'hF8 + 64'(i * 4), tb_mem[(62 + i) % DEPTH]));
            end
            if (i < 2) tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_write_collision();
        logic [31:0] old_w;
        logic [31:0] new_w;
        redirect(64'h10);
        old_w = tb_mem[5];
        new_w = ~old_w;
        out_ready = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 6'd5;
        prog_data = new_w;
        tick();
        prog_we   = 1'b0;
        out_ready = 1'b0;
        tb_mem[5] = new_w;
        checks++;
        if (obs !== pack(1'b1, 64'h14, old_w)) begin
            errors++;
            $display("FAIL collision_old: got %h expected %h", obs, pack(1'b1, 64'h14, old_w));
        end
        redirect(64'h14);
        checks++;
        if (obs !== pack(1'b1, 64'h14, new_w)) begin
            errors++;
            $display("FAIL collision_refetch: got %h expected %h", obs, pack(1'b1, 64'h14, new_w));
        end
    endtask

    task automatic test_reset_mid();
        redirect(64'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (obs !== pack(1'b0, 64'h0, 32'h0)) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obs, pack(1'b0, 64'h0, 32'h0));
        end
        branch_taken  = 1'b1;
        branch_target = 64'h40;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (obs !== pack(1'b0, 64'h0, 32'h0)) begin
            errors++;
            $display("FAIL idle_ignores_branch: got %h expected %h", obs, pack(1'b0, 64'h0, 32'h0));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (obs !== pack(1'b1, 64'h0, tb_mem[0])) begin
            errors++;
            $display("FAIL restart_replay: got %h expected %h", obs, pack(1'b1, 64'h0, tb_mem[0]));
        end
    endtask

    // Model tracks what decode should see: whether the stage is running, whether a
    // word is on offer, its address, and the word captured when it was presented.
    task automatic test_random();
        logic        m_running;
        logic        m_valid;
        logic [63:0] m_pc;
        logic [31:0] m_word;
        int          idx;
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        m_running = 1'b0;
        m_valid   = 1'b0;
        m_pc      = 64'h0;
        m_word    = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset         = ($urandom_range(0, 99) == 0);
            start         = ($urandom_range(0, 9) < 3);
            out_ready     = ($urandom_range(0, 9) < 7);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 511));
            prog_we       = ($urandom_range(0, 4) == 0);
            prog_addr     = AW'($urandom_range(0, DEPTH - 1));
            prog_data     = $urandom;

            if (reset) begin
                m_running = 1'b0;
                m_valid   = 1'b0;
                m_pc      = 64'h0;
                m_word    = 32'h0;
            end else if (!m_running) begin
                m_running = start;
            end else if (!m_valid) begin
                if (branch_taken) begin
                    m_pc = branch_target - (branch_target % 4);
                end else begin
                    idx     = int'((m_pc / 4) % DEPTH);
                    m_word  = tb_mem[idx];
                    m_valid = 1'b1;
                end
            end else if (branch_taken) begin
                m_pc    = branch_target - (branch_target % 4);
                m_valid = 1'b0;
            end else if (out_ready) begin
                m_pc   = m_pc + 64'd4;
                idx    = int'((m_pc / 4) % DEPTH);
                m_word = tb_mem[idx];
            end
            if (prog_we) tb_mem[int'(prog_addr)] = prog_data;

            tick();
            exp_v = pack(m_valid, m_pc, m_word);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", cyc, obs, exp_v);
            end
        end
        reset        = 1'b0;
        start        = 1'b0;
        prog_we      = 1'b0;
        branch_taken = 1'b0;
        out_ready    = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        out_ready     = 1'b0;

        test_reset();
        load_program();
        test_program_load();
        test_backpressure();
        test_branch();
        test_wrap();
        test_write_collision();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
